// File: rtl/glitch_filter_pkg.sv
// Shared constants and helpers for the glitch_filter deglitch block.
// Latency: n/a (package). Backpressure: n/a.
// Counter width helper keeps the top and any wrappers in agreement.
package glitch_filter_pkg;

  localparam int GF_STABLE_CNT_DEF  = 4;
  localparam int GF_SYNC_STAGES_DEF = 2;

  function automatic int gf_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/glitch_filter_sync.sv
// Purpose: SYNC_STAGES-deep flop chain bringing an async bit into the clock domain.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
module glitch_filter_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) chain <= RESET_VAL;
        else        chain <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) chain <= {SYNC_STAGES{RESET_VAL}};
        else        chain <= {chain[SYNC_STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Purpose: deglitch a noisy async pin; optional edge pulses under GLITCH_FILTER_EDGE_EN.
// Latency: sig_out follows after SYNC_STAGES+STABLE_CNT stable edges.
// Backpressure: none; free-running, one sample per clock.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int   STABLE_CNT  = GF_STABLE_CNT_DEF,
  parameter int   SYNC_STAGES = GF_SYNC_STAGES_DEF,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
`ifdef GLITCH_FILTER_EDGE_EN
  output logic rise_pulse,
  output logic fall_pulse,
`endif
  output logic sig_out
);

  localparam int            CW       = gf_cnt_w(STABLE_CNT);
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s;
  logic [CW-1:0] cnt;
  logic          update;

  glitch_filter_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (sig_in),
    .q     (s)
  );

  // Terminal count on a still-differing sample: commit the new level this edge.
  assign update = (s != sig_out) && (cnt == CNT_TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      sig_out <= RESET_VAL;
    end else if (s == sig_out) begin
      cnt <= '0;
    end else if (update) begin
      sig_out <= s;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

`ifdef GLITCH_FILTER_EDGE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= update &  s;
      fall_pulse <= update & ~s;
    end
  end
`endif

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter: per-cycle expected sig_out queued by the driver,
// checked by an independent monitor shortly after each rising edge.
module tb_glitch_filter;

  logic clock;
  logic reset;
  logic sig_in;
  logic sig_out;
`ifdef GLITCH_FILTER_EDGE_EN
  logic rise_pulse;
  logic fall_pulse;
`endif

  typedef struct {
    logic rst;
    logic exp;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;

  glitch_filter dut (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sig_in),
`ifdef GLITCH_FILTER_EDGE_EN
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
`endif
    .sig_out    (sig_out)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  // One vector element per cycle: drive at the falling edge, expectation is for
  // the value visible after the following rising edge.
  task automatic run_seq(input logic rst_v, input string ins, input string exps);
    for (int i = 0; i < ins.len(); i++) begin
      exp_t e;
      @(negedge clock);
      reset  = rst_v;
      sig_in = (ins[i] == "1");
      e.rst  = rst_v;
      e.exp  = (exps[i] == "1");
      q.push_back(e);
    end
  endtask

  // Monitor
  initial begin
    logic prev_exp;
    prev_exp = 1'b0;
    cyc      = 0;
    forever begin
      @(posedge clock);
      #5;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("sig_out", cyc, sig_out, e.exp);
`ifdef GLITCH_FILTER_EDGE_EN
        check("rise_pulse", cyc, rise_pulse, e.rst &&  e.exp && !prev_exp);
        check("fall_pulse", cyc, fall_pulse, e.rst && !e.exp &&  prev_exp);
`endif
        prev_exp = e.exp;
        cyc++;
      end
    end
  end

  initial begin
    int waited;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    sig_in = 1'b0;

    // Reset held while the pin toggles, then release with the pin low.
    run_seq(1'b0, "1010", "0000");
    run_seq(1'b1, "0000", "0000");

    // Single-cycle glitch.
    run_seq(1'b1, "100000", "000000");

    // Stable high, rejected low glitch, then stable low.
    run_seq(1'b1, "111111110111100000000",
                  "000001111111111111000");

    // Near threshold: 3 cycles rejected, 4 cycles accepted.
    run_seq(1'b1, "111000000", "000000000");
    run_seq(1'b1, "111100000000", "000001111000");

    // Reset pulse in the middle of a high run discards the partial count.
    run_seq(1'b1, "1111", "0000");
    run_seq(1'b0, "1", "0");
    run_seq(1'b1, "111111111", "000001111");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
